// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, fetches one
// 32-bit word per instruction over a req/ready handshake, holds it for the
// decoder until execute retires it, then computes the next PC from the
// jump / branch / sequential resolution. Halt opcode and memory timeout are
// terminal states that only reset can leave.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [5:0] HALT_OPCODE  = 6'h3f;
  // Last counter value before the timeout fires on the following edge.
  localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_req;
  logic [7:0]  r_cnt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;

  logic        w_take;
  logic        w_retire;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc_raw;
  logic [31:0] w_next_pc;

  // A handshake completes only while a request is actually outstanding, so a
  // stray imem_ready (e.g. one left over from before a reset) is ignored.
  assign w_take     = r_req & imem_ready;
  assign w_retire   = (r_state == S_HOLD) & advance & r_valid;
  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-PC selection: jump has priority over a taken branch; all arithmetic
  // wraps modulo 2^32 and the result is kept word aligned.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_next_pc_raw = w_pc_plus4;
    if (jump) begin
      w_next_pc_raw = {w_pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      w_next_pc_raw = w_pc_plus4 + (branch_offset << 2);
    end
    w_next_pc = {w_next_pc_raw[31:2], 2'b00};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: handshake, halt decode, timeout and retirement.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_take) begin
          w_next_state = (imem_rdata[31:26] == HALT_OPCODE) ? S_HALT : S_HOLD;
        end else if (r_req && (r_cnt == TIMEOUT_LAST)) begin
          w_next_state = S_ERR;
        end
      end
      S_HOLD: begin
        if (advance) begin
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = r_state;
      end
    endcase
  end

  // Datapath: request flag, timeout counter, instruction latch and PC.
  // The request is registered so it rises on the first edge after reset and
  // drops asynchronously the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_cnt   <= 8'd0;
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_instr <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_req <= (w_next_state == S_FETCH);
      if (w_take) begin
        r_instr <= imem_rdata;
        r_valid <= 1'b1;
        r_cnt   <= 8'd0;
      end else if (r_req) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_retire) begin
        r_valid <= 1'b0;
        r_pc    <= w_next_pc;
      end
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = (r_state == S_HALT);
  assign fetch_err   = (r_state == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Table-driven PC
// resolution vectors, randomized fetch/retire traffic against an arithmetic
// next-PC model, and hand-written halt, reset and timeout sequences.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        halted;
  logic        fetch_err;

  int n_total = 0;
  int n_pass  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .advance(advance), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .halted(halted), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    int          waits;
    logic        jump;
    logic [25:0] jt;
    logic        br;
    logic [31:0] off;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sample/drive point: just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC rule, expressed as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic j,
                                             input logic [25:0] t, input logic b,
                                             input logic [31:0] o);
    logic [31:0] p4;
    p4 = cur + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | (32'(t) * 32'd4);
    if (b) return p4 + o * 32'd4;
    return p4;
  endfunction

  // Serve one fetch at exp_addr after 'waits' unanswered cycles.
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr,
                           input int waits, input logic [31:0] word);
    int guard = 0;
    while (!imem_req && guard < 8) begin
      tick();
      guard++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
    for (int k = 0; k < waits; k++) begin
      imem_ready = 1'b0;
      tick();
      check({tag, "_wait_req"}, 32'(imem_req), 32'd1);
      check({tag, "_wait_addr"}, imem_addr, exp_addr);
      check({tag, "_wait_valid"}, 32'(instr_valid), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instruction, word);
    check({tag, "_pc"}, pc, exp_addr);
    check({tag, "_pc4"}, pc_plus4, exp_addr + 32'd4);
  endtask

  // Retire the held instruction; resolution inputs are first offered without
  // advance to show they are ignored, then qualified by advance.
  task automatic retire(input string tag, input logic [31:0] cur, input logic j,
                        input logic [25:0] t, input logic b, input logic [31:0] o,
                        input logic [31:0] exp_pc);
    jump = j; jump_target = t; branch_taken = b; branch_offset = o;
    advance = 1'b0;
    tick();
    check({tag, "_noadv_pc"}, pc, cur);
    check({tag, "_noadv_req"}, 32'(imem_req), 32'd0);
    advance = 1'b1;
    tick();
    advance = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    check({tag, "_npc"}, pc, exp_pc);
    check({tag, "_nreq"}, 32'(imem_req), 32'd1);
    check({tag, "_nvalid"}, 32'(instr_valid), 32'd0);
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] a);
    logic [31:0] w;
    w = a ^ 32'h1234_5678;
    if (w[31:26] == 6'h3f) w[26] = 1'b0;
    return w;
  endfunction

  initial begin
    logic [31:0] mpc;
    int req_seen;

    vecs[0] = '{"seq_8",     32'h0000_0008, 3, 1'b0, 26'h0,      1'b0, 32'h0,         32'h0000_000C};
    vecs[1] = '{"seq_c",     32'h0000_000C, 0, 1'b0, 26'h0,      1'b0, 32'h0,         32'h0000_0010};
    vecs[2] = '{"br_taken",  32'h0000_0010, 1, 1'b0, 26'h0,      1'b1, 32'hFFFF_FFFE, 32'h0000_000C};
    vecs[3] = '{"seq_back",  32'h0000_000C, 0, 1'b0, 26'h0,      1'b0, 32'h0,         32'h0000_0010};
    vecs[4] = '{"br_not",    32'h0000_0010, 2, 1'b0, 26'h0,      1'b0, 32'hFFFF_FFFE, 32'h0000_0014};
    vecs[5] = '{"br_far",    32'h0000_0014, 0, 1'b0, 26'h0,      1'b1, 32'h1000_0002, 32'h4000_0020};
    vecs[6] = '{"jump_prio", 32'h4000_0020, 1, 1'b1, 26'h000_0100, 1'b1, 32'h0000_0005, 32'h4000_0400};
    vecs[7] = '{"br_wrap",   32'h4000_0400, 0, 1'b0, 26'h0,      1'b1, 32'h2FFF_FEFF, 32'h0000_0000};
    vecs[8] = '{"jump_low",  32'h0000_0000, 2, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,       32'h0FFF_FFFC};

    rst = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; advance = 1'b0;
    branch_taken = 1'b0; branch_offset = 32'h0; jump = 1'b0; jump_target = 26'h0;

    // Reset state.
    tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);

    // Zero-wait sequential timing: req on cycles 1, 3, 5.
    rst = 1'b1;
    check("rel_req_low", 32'(imem_req), 32'd0);
    tick();
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", imem_addr, 32'h0);
    imem_ready = 1'b1; imem_rdata = 32'h0000_1111;
    tick();
    imem_ready = 1'b0;
    check("c2_valid", 32'(instr_valid), 32'd1);
    check("c2_req", 32'(imem_req), 32'd0);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check("c3_req", 32'(imem_req), 32'd1);
    check("c3_addr", imem_addr, 32'h4);
    imem_ready = 1'b1; imem_rdata = 32'h0000_2222;
    tick();
    imem_ready = 1'b0;
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check("c5_req", 32'(imem_req), 32'd1);
    check("c5_addr", imem_addr, 32'h8);

    // Table-driven PC resolution.
    for (int i = 0; i < 9; i++) begin
      fetch_one(vecs[i].name, vecs[i].start_pc, vecs[i].waits, word_for(vecs[i].start_pc));
      retire(vecs[i].name, vecs[i].start_pc, vecs[i].jump, vecs[i].jt,
             vecs[i].br, vecs[i].off, vecs[i].exp_pc);
    end

    // Randomized traffic against the reference model.
    mpc = 32'h0FFF_FFFC;
    for (int i = 0; i < 40; i++) begin
      logic        rj, rb;
      logic [25:0] rt;
      logic [31:0] ro, nxt;
      rj = ($urandom_range(0, 3) == 0);
      rb = ($urandom_range(0, 1) == 1);
      rt = 26'($urandom);
      ro = 32'($urandom_range(0, 63)) - 32'd32;
      nxt = model_next(mpc, rj, rt, rb, ro);
      fetch_one("rnd", mpc, $urandom_range(0, 4), word_for(mpc ^ 32'($urandom)));
      retire("rnd", mpc, rj, rt, rb, ro, nxt);
      mpc = nxt;
    end

    // Halt: sticky, no further requests despite advance.
    fetch_one("halt", mpc, 1, 32'hFC00_0000);
    check("halt_flag", 32'(halted), 32'd1);
    req_seen = 0;
    for (int k = 0; k < 20; k++) begin
      advance = k[0]; jump = 1'b1; branch_taken = 1'b1;
      tick();
      if (imem_req) req_seen++;
    end
    advance = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    check("halt_req_quiet", 32'(req_seen), 32'd0);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_valid", 32'(instr_valid), 32'd1);
    check("halt_pc", pc, mpc);
    check("halt_instr", instruction, 32'hFC00_0000);

    // Reset mid-request at pc 0x8.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    fetch_one("r_0", 32'h0, 0, 32'h0000_0001);
    retire("r_0", 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h4);
    fetch_one("r_4", 32'h4, 0, 32'h0000_0002);
    retire("r_4", 32'h4, 1'b0, 26'h0, 1'b0, 32'h0, 32'h8);
    check("mid_req_hi", 32'(imem_req), 32'd1);
    #2;
    rst = 1'b0;
    imem_ready = 1'b1; imem_rdata = 32'h0000_0003;
    #1;
    check("mid_req_drop", 32'(imem_req), 32'd0);
    check("mid_halted_clr", 32'(halted), 32'd0);
    tick();
    check("mid_pc", pc, 32'h0);
    check("mid_valid", 32'(instr_valid), 32'd0);
    imem_ready = 1'b0;
    rst = 1'b1;

    // Timeout: request never answered.
    tick();
    check("to_req", 32'(imem_req), 32'd1);
    check("to_addr", imem_addr, 32'h0);
    for (int k = 0; k < 15; k++) tick();
    check("to_err_15", 32'(fetch_err), 32'd0);
    tick();
    check("to_err_16", 32'(fetch_err), 32'd1);
    check("to_valid", 32'(instr_valid), 32'd0);
    check("to_req_low", 32'(imem_req), 32'd0);
    imem_ready = 1'b1;
    tick(); tick();
    imem_ready = 1'b0;
    check("to_sticky", 32'(fetch_err), 32'd1);
    check("to_no_latch", 32'(instr_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
